// File: rtl/avalon_mc_fifo_csr.sv
// Multi-channel single-clock FIFO bank: Avalon-MM write/read ports, per-channel CSRs and level irq.
// Build macro MCFIFO_DROP_ON_FULL_EN: writes to a full channel are dropped (overflow event) instead of stalled.
module avalon_mc_fifo_csr #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [DATA_W-1:0] in_writedata,
  input  logic              in_write,
  output logic              in_waitrequest,
  input  logic [CH_W-1:0]   out_channel,
  input  logic              out_read,
  output logic [DATA_W-1:0] out_readdata,
  output logic              out_readdatavalid,
  input  logic [CH_W-1:0]   csr_channel,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq
);
  localparam int PW = LVL_W - 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [CHANNELS][DEPTH];

  logic [LVL_W-1:0]  wr_ptr_q [CHANNELS], wr_ptr_d [CHANNELS];
  logic [LVL_W-1:0]  rd_ptr_q [CHANNELS], rd_ptr_d [CHANNELS];
  logic [LVL_W-1:0]  fill_q   [CHANNELS], fill_d   [CHANNELS];
  logic [LVL_W-1:0]  af_q     [CHANNELS], af_d     [CHANNELS];
  logic [LVL_W-1:0]  ae_q     [CHANNELS], ae_d     [CHANNELS];
  logic [5:0]        event_q  [CHANNELS], event_d  [CHANNELS];
  logic [5:0]        ien_q    [CHANNELS], ien_d    [CHANNELS];
  logic [5:0]        status   [CHANNELS];
  logic [5:0]        clr      [CHANNELS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       csr_rdata_q, csr_rdata_d;
  logic              irq_q, irq_d;

  logic [CHANNELS-1:0] full, empty, push, pop, ovf, unf;
  logic                push_ok, pop_ok;
  logic                unused_bits;

`ifdef MCFIFO_DROP_ON_FULL_EN
  assign in_waitrequest = 1'b0;
  assign push_ok        = in_write && !full[in_channel];
`else
  assign in_waitrequest = full[in_channel];
  assign push_ok        = in_write && !in_waitrequest;
`endif
  // An empty channel never bypasses a same-cycle push to the read side.
  assign pop_ok = out_read && !empty[out_channel];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]  = (fill_q[c] == FULL_LVL);
      empty[c] = (fill_q[c] == '0);
      push[c]  = push_ok && (in_channel == CH_W'(c));
      pop[c]   = pop_ok && (out_channel == CH_W'(c));
      unf[c]   = out_read && (out_channel == CH_W'(c)) && empty[c];
`ifdef MCFIFO_DROP_ON_FULL_EN
      ovf[c]   = in_write && (in_channel == CH_W'(c)) && full[c];
`else
      ovf[c]   = 1'b0;
`endif
      status[c] = {unf[c], ovf[c], (fill_q[c] <= ae_q[c]), (fill_q[c] >= af_q[c]),
                   empty[c], full[c]};
    end
  end

  always_comb begin
    rdata_d     = rdata_q;
    rvalid_d    = pop_ok;
    csr_rdata_d = csr_rdata_q;
    irq_d       = 1'b0;
    if (pop_ok) begin
      rdata_d = mem_q[out_channel][rd_ptr_q[out_channel][PW-1:0]];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      af_d[c]     = af_q[c];
      ae_d[c]     = ae_q[c];
      ien_d[c]    = ien_q[c];
      if (push[c]) wr_ptr_d[c] = {1'b0, wr_ptr_q[c][PW-1:0] + PW'(1)};
      if (pop[c])  rd_ptr_d[c] = {1'b0, rd_ptr_q[c][PW-1:0] + PW'(1)};
      fill_d[c] = fill_q[c] + LVL_W'(push[c]) - LVL_W'(pop[c]);
      clr[c] = (csr_write && csr_address == 3'd2 && csr_channel == CH_W'(c))
               ? csr_writedata[5:0] : 6'd0;
      // Setting status wins over a same-cycle write-1-to-clear.
      event_d[c] = (event_q[c] & ~clr[c]) | status[c];
      if (csr_write && csr_channel == CH_W'(c)) begin
        case (csr_address)
          3'd3:    ien_d[c] = csr_writedata[5:0];
          3'd4:    af_d[c]  = csr_writedata[LVL_W-1:0];
          3'd5:    ae_d[c]  = csr_writedata[LVL_W-1:0];
          default: ;
        endcase
      end
      irq_d = irq_d | (|(event_q[c] & ien_q[c]));
    end
    if (csr_read) begin
      csr_rdata_d = '0;
      case (csr_address)
        3'd0:    csr_rdata_d[LVL_W-1:0] = fill_q[csr_channel];
        3'd1:    csr_rdata_d[5:0]       = status[csr_channel];
        3'd2:    csr_rdata_d[5:0]       = event_q[csr_channel];
        3'd3:    csr_rdata_d[5:0]       = ien_q[csr_channel];
        3'd4:    csr_rdata_d[LVL_W-1:0] = af_q[csr_channel];
        3'd5:    csr_rdata_d[LVL_W-1:0] = ae_q[csr_channel];
        default: ;
      endcase
    end
  end

  always_comb begin
    unused_bits = ^csr_writedata[31:LVL_W];
    for (int c = 0; c < CHANNELS; c++) begin
      unused_bits = unused_bits ^ wr_ptr_q[c][PW] ^ rd_ptr_q[c][PW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
        event_q[c]  <= '0;
        ien_q[c]    <= '0;
        af_q[c]     <= LVL_W'(DEPTH - 1);
        ae_q[c]     <= LVL_W'(1);
      end
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      csr_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        fill_q[c]   <= fill_d[c];
        event_q[c]  <= event_d[c];
        ien_q[c]    <= ien_d[c];
        af_q[c]     <= af_d[c];
        ae_q[c]     <= ae_d[c];
      end
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      csr_rdata_q <= csr_rdata_d;
      irq_q       <= irq_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[in_channel][wr_ptr_q[in_channel][PW-1:0]] <= in_writedata;
    end
  end

  assign out_readdata      = rdata_q;
  assign out_readdatavalid = rvalid_q;
  assign csr_readdata      = csr_rdata_q;
  assign irq               = irq_q;
endmodule

// File: tb/tb_avalon_mc_fifo_csr.sv
// Bench for avalon_mc_fifo_csr: directed steps plus random traffic against a queue-based model.
module tb_avalon_mc_fifo_csr;
  localparam int DATA_W = 32, DEPTH = 64, CHANNELS = 4, CH_W = 2, LVL_W = 7;
`ifdef MCFIFO_DROP_ON_FULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [CH_W-1:0]   in_channel, out_channel, csr_channel;
  logic [DATA_W-1:0] in_writedata, out_readdata;
  logic              in_write, in_waitrequest, out_read, out_readdatavalid;
  logic [2:0]        csr_address;
  logic              csr_read, csr_write, irq;
  logic [31:0]       csr_writedata, csr_readdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq   [CHANNELS][$];
  logic [5:0]  mev  [CHANNELS];
  logic [5:0]  mien [CHANNELS];
  int          maf  [CHANNELS];
  int          mae  [CHANNELS];

  always #5 clk = ~clk;

  avalon_mc_fifo_csr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_channel(in_channel), .in_writedata(in_writedata), .in_write(in_write),
    .in_waitrequest(in_waitrequest),
    .out_channel(out_channel), .out_read(out_read), .out_readdata(out_readdata),
    .out_readdatavalid(out_readdatavalid),
    .csr_channel(csr_channel), .csr_address(csr_address), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      mq[c].delete();
      mev[c]  = '0;
      mien[c] = '0;
      maf[c]  = DEPTH - 1;
      mae[c]  = 1;
    end
  endtask

  function automatic logic [5:0] mstat(input int c, input bit w, input int wch,
                                       input bit r, input int rch);
    int n;
    logic [5:0] s;
    n = mq[c].size();
    s[0] = (n == DEPTH);
    s[1] = (n == 0);
    s[2] = (n >= maf[c]);
    s[3] = (n <= mae[c]);
    s[4] = DROP && w && (wch == c) && (n == DEPTH);
    s[5] = r && (rch == c) && (n == 0);
    return s;
  endfunction

  task automatic set_idle();
    in_write = 1'b0; in_channel = '0; in_writedata = '0;
    out_read = 1'b0; out_channel = '0;
    csr_read = 1'b0; csr_write = 1'b0; csr_channel = '0; csr_address = '0; csr_writedata = '0;
  endtask

  // One clock of traffic: drive, predict from the model, clock, compare.
  task automatic do_cycle(input bit w, input int wch, input logic [31:0] wd,
                          input bit r, input int rch,
                          input bit cr, input bit cw, input int cch, input int caddr,
                          input logic [31:0] cwd);
    logic [5:0]  st [CHANNELS];
    logic [5:0]  c2;
    logic [31:0] exp_csr, exp_rd;
    bit          exp_vld, exp_irq, wok;
    in_write = w; in_channel = CH_W'(wch); in_writedata = wd;
    out_read = r; out_channel = CH_W'(rch);
    csr_read = cr; csr_write = cw; csr_channel = CH_W'(cch);
    csr_address = 3'(caddr); csr_writedata = cwd;
    #1;
    chk("waitrequest", 32'(in_waitrequest), 32'(!DROP && mq[wch].size() == DEPTH));
    exp_irq = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      st[c] = mstat(c, w, wch, r, rch);
      exp_irq = exp_irq | (|(mev[c] & mien[c]));
    end
    case (caddr)
      0:       exp_csr = 32'(mq[cch].size());
      1:       exp_csr = 32'(st[cch]);
      2:       exp_csr = 32'(mev[cch]);
      3:       exp_csr = 32'(mien[cch]);
      4:       exp_csr = 32'(maf[cch]);
      5:       exp_csr = 32'(mae[cch]);
      default: exp_csr = 32'd0;
    endcase
    wok = w && (mq[wch].size() < DEPTH);
    exp_vld = r && (mq[rch].size() > 0);
    exp_rd = '0;
    if (exp_vld) exp_rd = mq[rch].pop_front();
    if (wok) mq[wch].push_back(wd);
    for (int c = 0; c < CHANNELS; c++) begin
      c2 = (cw && caddr == 2 && cch == c) ? cwd[5:0] : 6'd0;
      mev[c] = (mev[c] & ~c2) | st[c];
    end
    if (cw) begin
      case (caddr)
        3:       mien[cch] = cwd[5:0];
        4:       maf[cch]  = int'(cwd[LVL_W-1:0]);
        5:       mae[cch]  = int'(cwd[LVL_W-1:0]);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk("readdatavalid", 32'(out_readdatavalid), 32'(exp_vld));
    if (exp_vld) chk("readdata", out_readdata, exp_rd);
    if (cr) chk($sformatf("csr ch%0d reg%0d", cch, caddr), csr_readdata, exp_csr);
    chk("irq", 32'(irq), 32'(exp_irq));
    set_idle();
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    do_cycle(1'b1, ch, d, 1'b0, 0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask
  task automatic pop(input int ch);
    do_cycle(1'b0, 0, 32'd0, 1'b1, ch, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask
  task automatic csr_rd(input int ch, input int a);
    do_cycle(1'b0, 0, 32'd0, 1'b0, 0, 1'b1, 1'b0, ch, a, 32'd0);
  endtask
  task automatic csr_wr(input int ch, input int a, input logic [31:0] d);
    do_cycle(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 1'b1, ch, a, d);
  endtask
  task automatic idle();
    do_cycle(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask

  initial begin
    set_idle();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst waitrequest", 32'(in_waitrequest), 32'd0);
    chk("rst readdata", out_readdata, 32'd0);
    chk("rst readdatavalid", 32'(out_readdatavalid), 32'd0);
    chk("rst csr_readdata", csr_readdata, 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    reset_n = 1'b1;

    // ch2 ordered push/pop
    for (int i = 0; i < 4; i++) push(2, 32'hA0 + 32'(i));
    csr_rd(2, 0);
    chk("ch2 fill 4", csr_readdata, 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop(2);
      chk("ch2 pop data", out_readdata, 32'hA0 + 32'(i));
    end
    csr_rd(2, 0);
    chk("ch2 fill 0", csr_readdata, 32'd0);

    // interleaved channels
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h100 + 32'(i));
      push(3, 32'h300 + 32'(i));
    end
    csr_rd(1, 0);
    chk("ch1 fill untouched", csr_readdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pop(3);
      chk("ch3 data", out_readdata, 32'h300 + 32'(i));
      pop(0);
      chk("ch0 data", out_readdata, 32'h100 + 32'(i));
    end

    // fill ch1 completely
    for (int i = 0; i < DEPTH; i++) push(1, $urandom);
    csr_rd(1, 1);
    chk("ch1 full bit", csr_readdata & 32'h1, 32'h1);
    in_write = 1'b1; in_channel = 2'd1;
    #1;
    chk("ch1 stall when full", 32'(in_waitrequest), 32'(!DROP));
    push(1, 32'hDEAD_BEEF);
    csr_rd(1, 0);
    chk("ch1 fill stays DEPTH", csr_readdata, 32'(DEPTH));
    csr_rd(1, 2);
    chk("ch1 overflow event", (csr_readdata >> 4) & 32'h1, 32'(DROP));
    for (int i = 0; i < DEPTH; i++) pop(1);

    // underflow and irq
    pop(0);
    chk("empty pop no valid", 32'(out_readdatavalid), 32'd0);
    csr_rd(0, 2);
    chk("underflow event", (csr_readdata >> 5) & 32'h1, 32'h1);
    csr_wr(0, 3, 32'h20);
    idle();
    chk("irq raised", 32'(irq), 32'd1);
    csr_wr(0, 2, 32'h20);
    idle();
    chk("irq cleared", 32'(irq), 32'd0);

    // almost-full threshold and simultaneous push/pop
    csr_wr(1, 4, 32'd8);
    for (int i = 0; i < 7; i++) push(1, 32'h1000 + 32'(i));
    csr_rd(1, 1);
    chk("af below threshold", (csr_readdata >> 2) & 32'h1, 32'h0);
    push(1, 32'h1007);
    csr_rd(1, 1);
    chk("af at threshold", (csr_readdata >> 2) & 32'h1, 32'h1);
    do_cycle(1'b1, 1, 32'h1008, 1'b1, 1, 1'b0, 1'b0, 0, 0, 32'd0);
    chk("push+pop data", out_readdata, 32'h1000);
    csr_rd(1, 0);
    chk("push+pop fill", csr_readdata, 32'd8);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      int sel;
      bit w, r, cr, cw;
      int ca;
      logic [31:0] cd;
      w  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5);
      sel = $urandom_range(0, 9);
      cr = (sel < 3);
      cw = (sel == 3);
      ca = $urandom_range(0, 7);
      cd = (ca == 4 || ca == 5) ? 32'($urandom_range(0, DEPTH)) : $urandom;
      do_cycle(w, $urandom_range(0, 3), $urandom, r, $urandom_range(0, 3),
               cr, cw, $urandom_range(0, 3), ca, cd);
    end

    // reset during operation
    for (int i = 0; i < 5; i++) push(2, 32'h5000 + 32'(i));
    csr_wr(2, 4, 32'd20);
    pop(2);
    reset_n = 1'b0;
    #1;
    chk("midrst readdatavalid", 32'(out_readdatavalid), 32'd0);
    chk("midrst readdata", out_readdata, 32'd0);
    chk("midrst irq", 32'(irq), 32'd0);
    chk("midrst csr_readdata", csr_readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    csr_rd(2, 0);
    chk("post-rst fill", csr_readdata, 32'd0);
    csr_rd(2, 4);
    chk("post-rst AF", csr_readdata, 32'd63);
    csr_rd(2, 5);
    chk("post-rst AE", csr_readdata, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
